// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: bus widths, command codes and FSM encodings.
package sdram_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BANK_W = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_MRS       = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_AREF      = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM command bus between init, auto-refresh, write and read
// engines, with round-robin write/read fairness and a per-grant watchdog.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 10,
    parameter logic [3:0]  CMD_NOP = sdram_pkg::CMD_NOP
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        aref_ask,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    input  logic        wr_ask,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        rd_ask,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        dq_oe,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    output logic        timeout_err
);

    import sdram_pkg::*;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_d;

    // State, fairness flag, watchdog and error pulse registers
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_READ;
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_err  <= timeout_d;
        end
    end

    // Next state; the owner's own end wins over a coincident watchdog expiry
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = '0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (init_end) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                if (aref_ask) begin
                    state_d = S_AREF;
                end else if (wr_ask && (!rd_ask || last_grant_q == GRANT_READ)) begin
                    state_d      = S_WRITE;
                    last_grant_d = GRANT_WRITE;
                end else if (rd_ask) begin
                    state_d      = S_READ;
                    last_grant_d = GRANT_READ;
                end
            end
            S_AREF, S_WRITE, S_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((state_q == S_AREF  && aref_end) ||
                    (state_q == S_WRITE && wr_end)   ||
                    (state_q == S_READ  && rd_end)) begin
                    state_d = S_ARBIT;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_ARBIT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant enables and command/address/bank mux
    always_comb begin
        aref_en    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        dq_oe      = 1'b0;
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = '0;
        case (state_q)
            S_ARBIT: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
            end
            S_AREF: begin
                aref_en    = 1'b1;
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                wr_en      = ~aref_ask;
                dq_oe      = 1'b1;
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_READ: begin
                rd_en      = ~aref_ask;
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// phase, all outputs compared each cycle against an owner-level reference model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int unsigned TIMEOUT = 1000;
    localparam int O_IDLE = 0, O_ARBIT = 1, O_AREF = 2, O_WR = 3, O_RD = 4;

    logic        sclk = 1'b0;
    logic        srst;
    logic        init_end, aref_ask, aref_end, wr_ask, wr_end, rd_ask, rd_end;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic        aref_en, wr_en, rd_en, dq_oe, timeout_err;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    sdram_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(10), .CMD_NOP(CMD_NOP)) dut (
        .sclk(sclk), .srst(srst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_ask(aref_ask), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_ask(wr_ask), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_ask(rd_ask), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .dq_oe(dq_oe),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .timeout_err(timeout_err)
    );

    always #5 sclk = ~sclk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    // Reference model: who owns the bus, whose turn it is, how long it has held it
    int    m_owner;
    bit    m_write_next;
    int    m_age;
    bit    m_terr;
    int    m_burst;
    bit    auto_end;
    int    burst_lo, burst_hi;
    string glog;
    bit    p_aref, p_dq, p_rd;
    logic [3:0] cmd_tab [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %s expected %s", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner      = O_IDLE;
        m_write_next = 1'b1;
        m_age        = 0;
        m_terr       = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0]  ecmd;
        logic [11:0] eaddr;
        logic [1:0]  ebank;
        ecmd = init_cmd; eaddr = init_addr; ebank = 2'd0;
        case (m_owner)
            O_ARBIT: begin ecmd = CMD_NOP;  eaddr = 12'd0; end
            O_AREF:  begin ecmd = aref_cmd; eaddr = aref_addr; end
            O_WR:    begin ecmd = wr_cmd;   eaddr = wr_addr; ebank = wr_bank; end
            O_RD:    begin ecmd = rd_cmd;   eaddr = rd_addr; ebank = rd_bank; end
            default: ;
        endcase
        chk("aref_en", 32'(aref_en), 32'(m_owner == O_AREF));
        chk("wr_en", 32'(wr_en), 32'(m_owner == O_WR && !aref_ask));
        chk("rd_en", 32'(rd_en), 32'(m_owner == O_RD && !aref_ask));
        chk("dq_oe", 32'(dq_oe), 32'(m_owner == O_WR));
        chk("sdram_cmd", 32'(sdram_cmd), 32'(ecmd));
        chk("sdram_addr", 32'(sdram_addr), 32'(eaddr));
        chk("sdram_bank", 32'(sdram_bank), 32'(ebank));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (aref_en && !p_aref) glog = {glog, "A"};
        if (dq_oe && !p_dq)     glog = {glog, "W"};
        if (rd_en && !p_rd)     glog = {glog, "R"};
        p_aref = aref_en; p_dq = dq_oe; p_rd = rd_en;
    endtask

    task automatic randomize_payload();
        init_cmd  = cmd_tab[$urandom_range(0, 5)];
        aref_cmd  = cmd_tab[$urandom_range(0, 5)];
        wr_cmd    = cmd_tab[$urandom_range(0, 5)];
        rd_cmd    = cmd_tab[$urandom_range(0, 5)];
        init_addr = 12'($urandom);
        aref_addr = 12'($urandom);
        wr_addr   = 12'($urandom);
        rd_addr   = 12'($urandom);
        wr_bank   = 2'($urandom);
        rd_bank   = 2'($urandom);
    endtask

    // One clock: predict from current inputs, advance, check, then drive next inputs
    task automatic cycle();
        int n_owner, n_age, served;
        bit n_terr, n_wn, done;
        n_owner = m_owner; n_age = m_age; n_terr = 1'b0; n_wn = m_write_next;
        if (srst) begin
            n_owner = O_IDLE; n_age = 0; n_wn = 1'b1;
        end else begin
            case (m_owner)
                O_IDLE: if (init_end) n_owner = O_ARBIT;
                O_ARBIT: begin
                    n_age = 0;
                    if (aref_ask) n_owner = O_AREF;
                    else if (wr_ask && rd_ask) begin
                        n_owner = m_write_next ? O_WR : O_RD;
                        n_wn    = !m_write_next;
                    end else if (wr_ask) begin n_owner = O_WR; n_wn = 1'b0; end
                    else if (rd_ask)     begin n_owner = O_RD; n_wn = 1'b1; end
                end
                default: begin
                    served = m_age + 1;
                    done = (m_owner == O_AREF && aref_end) || (m_owner == O_WR && wr_end) ||
                           (m_owner == O_RD && rd_end);
                    if (done) n_owner = O_ARBIT;
                    else if (served == int'(TIMEOUT)) begin n_owner = O_ARBIT; n_terr = 1'b1; end
                    n_age = served;
                end
            endcase
        end
        @(posedge sclk);
        if (m_owner == O_ARBIT && n_owner >= O_AREF) m_burst = $urandom_range(burst_hi, burst_lo);
        m_owner = n_owner; m_age = n_age; m_terr = n_terr; m_write_next = n_wn;
        @(negedge sclk);
        cyc++;
        check_outputs();
        randomize_payload();
        aref_end = auto_end && m_owner == O_AREF && m_age == m_burst - 1;
        wr_end   = auto_end && m_owner == O_WR   && m_age == m_burst - 1;
        rd_end   = auto_end && m_owner == O_RD   && m_age == m_burst - 1;
    endtask

    task automatic wait_owner(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && m_owner != target; i++) cycle();
        if (m_owner != target) begin
            checks++; errors++;
            $error("FAIL %s bound expired owner %0d expected %0d", tag, m_owner, target);
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && glog.len() < n; i++) cycle();
    endtask

    int n_rd, n_te;

    initial begin
        cmd_tab[0] = CMD_MRS;    cmd_tab[1] = CMD_AREF;  cmd_tab[2] = CMD_PRECHARGE;
        cmd_tab[3] = CMD_ACTIVE; cmd_tab[4] = CMD_WRITE; cmd_tab[5] = CMD_READ;
        srst = 1'b1;
        {init_end, aref_ask, aref_end, wr_ask, wr_end, rd_ask, rd_end} = '0;
        randomize_payload();
        model_reset();
        auto_end = 1'b1; burst_lo = 3; burst_hi = 6; m_burst = 1;
        glog = ""; p_aref = 0; p_dq = 0; p_rd = 0;

        // Reset values, then init_end pulse at cycle 20
        repeat (3) cycle();
        srst = 1'b0;
        while (cyc < 20) cycle();
        init_end = 1'b1;
        cycle();
        init_end = 1'b0;
        chk("arbit_cmd", 32'(sdram_cmd), 32'(CMD_NOP));
        chk("arbit_addr", 32'(sdram_addr), 32'd0);

        // Write and read held together alternate, write first
        glog = "";
        wr_ask = 1'b1; rd_ask = 1'b1;
        wait_grants(3, 200);
        wr_ask = 1'b0; rd_ask = 1'b0;
        chk_str("wr_rd_order", glog, "WRW");
        wait_owner(O_ARBIT, 100, "drain1");

        // Refresh beats a simultaneous write
        glog = "";
        aref_ask = 1'b1; wr_ask = 1'b1;
        cycle();
        aref_ask = 1'b0;
        wait_grants(2, 200);
        wr_ask = 1'b0;
        chk_str("aref_first", glog, "AW");
        wait_owner(O_ARBIT, 100, "drain2");

        // Refresh request mid-write masks wr_en but lets the burst finish
        glog = ""; burst_lo = 8; burst_hi = 8;
        wr_ask = 1'b1;
        wait_owner(O_WR, 20, "enter_wr");
        wr_ask = 1'b0;
        repeat (2) cycle();
        aref_ask = 1'b1;
        cycle();
        chk("wr_en_masked", 32'(wr_en), 32'd0);
        chk("dq_oe_masked", 32'(dq_oe), 32'd1);
        wait_grants(2, 100);
        aref_ask = 1'b0;
        chk_str("wr_then_aref", glog, "WA");
        wait_owner(O_ARBIT, 100, "drain3");

        // Read with no end: forced release after TIMEOUT cycles, one error pulse
        auto_end = 1'b0; n_rd = 0; n_te = 0;
        rd_ask = 1'b1;
        cycle();
        rd_ask = 1'b0;
        if (rd_en) n_rd++;
        for (int i = 0; i < int'(TIMEOUT) + 3; i++) begin
            cycle();
            if (rd_en) n_rd++;
            if (timeout_err) n_te++;
        end
        chk("timeout_len", 32'(n_rd), 32'(TIMEOUT));
        chk("timeout_pulses", 32'(n_te), 32'd1);

        // End on the last allowed cycle counts as a normal finish
        auto_end = 1'b1; burst_lo = int'(TIMEOUT); burst_hi = int'(TIMEOUT);
        n_rd = 0; n_te = 0;
        rd_ask = 1'b1;
        cycle();
        rd_ask = 1'b0;
        if (rd_en) n_rd++;
        for (int i = 0; i < int'(TIMEOUT) + 3; i++) begin
            cycle();
            if (rd_en) n_rd++;
            if (timeout_err) n_te++;
        end
        chk("late_end_len", 32'(n_rd), 32'(TIMEOUT));
        chk("late_end_pulses", 32'(n_te), 32'd0);

        // Asynchronous reset in the middle of a write burst
        burst_lo = 20; burst_hi = 20;
        wr_ask = 1'b1;
        wait_owner(O_WR, 20, "enter_wr2");
        wr_ask = 1'b0;
        repeat (3) cycle();
        #2 srst = 1'b1;
        wr_end = 1'b0;
        #1;
        model_reset();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_cmd", 32'(sdram_cmd), 32'(init_cmd));
        check_outputs();
        repeat (2) cycle();
        srst = 1'b0;
        cycle();
        init_end = 1'b1;
        cycle();
        init_end = 1'b0;
        glog = ""; burst_lo = 2; burst_hi = 5;
        wr_ask = 1'b1; rd_ask = 1'b1;
        wait_grants(1, 50);
        wr_ask = 1'b0; rd_ask = 1'b0;
        chk_str("post_rst_write_first", glog, "W");
        wait_owner(O_ARBIT, 100, "drain4");

        // Randomized traffic, including stray init_end and non-owner end strobes
        burst_lo = 1; burst_hi = 12;
        for (int i = 0; i < 3000; i++) begin
            wr_ask   = ($urandom_range(0, 3) != 0);
            rd_ask   = ($urandom_range(0, 2) != 0);
            aref_ask = ($urandom_range(0, 9) == 0);
            init_end = ($urandom_range(0, 7) == 0);
            if (m_owner != O_RD && $urandom_range(0, 9) == 0) rd_end = 1'b1;
            if (m_owner != O_WR && $urandom_range(0, 9) == 0) wr_end = 1'b1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
